// File: rtl/spi_mem_pkg.sv
// -----------------------------------------------------------------------------
// spi_mem_pkg
//   Shared definitions for the SPI SRAM initiator:
//     - 23LC-style command opcodes (READ / WRITE)
//     - SPI mode-0 clock polarity / phase constants
//     - FSM state encoding used by spi_mem_master
//     - cmd_for(): picks the opcode for a request direction
// -----------------------------------------------------------------------------
package spi_mem_pkg;

    // 23LC-style single-byte command opcodes.
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    // SPI mode 0: SCLK idles low, data sampled on the leading (rising) edge
    // and changed on the trailing (falling) edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    function automatic logic [7:0] cmd_for(input logic we);
        return we ? CMD_WRITE : CMD_READ;
    endfunction

endpackage : spi_mem_pkg

// File: rtl/spi_sclk_div.sv
// -----------------------------------------------------------------------------
// spi_sclk_div
//   SCLK generator. While en is high, SCLK toggles every CLK_DIV clk cycles,
//   the first toggle leaving the idle level. While en is low the half-period
//   counter is cleared and SCLK is parked at its idle level, so every enable
//   window starts with a full half-period before the first edge.
//
// Ports
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   en     in   run the divider
//   sclk   out  registered SPI clock
//   rise   out  single-cycle strobe: sclk goes high on the coming clk edge
//   fall   out  single-cycle strobe: sclk goes low on the coming clk edge
// -----------------------------------------------------------------------------
module spi_sclk_div
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int DW = $clog2(CLK_DIV + 1);

    logic [DW-1:0] cnt_q;
    logic          terminal;

    // The strobes announce the edge that the next clk edge will produce, so a
    // consumer acting on the same clk edge sees MISO/MOSI exactly as they were
    // just before the SCLK transition.
    assign terminal = en && (cnt_q == DW'(CLK_DIV - 1));
    assign rise     = terminal && (sclk == SPI_CPOL);
    assign fall     = terminal && (sclk != SPI_CPOL);

    // NOTE: reset is synchronous, so it sits inside the clocked block and is
    // sampled like any other input; all state updates use <= so every
    // register sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sclk  <= SPI_CPOL;
        end else if (!en) begin
            cnt_q <= '0;
            sclk  <= SPI_CPOL;
        end else if (terminal) begin
            cnt_q <= '0;
            sclk  <= ~sclk;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule : spi_sclk_div

// File: rtl/spi_mem_master.sv
// -----------------------------------------------------------------------------
// spi_mem_master
//   SPI mode-0 initiator that turns single-byte CPU memory requests into
//   23LC-style SRAM frames: {cmd, big-endian address, data}, MSB first.
//   Reads send 0x00 in the data slot and return the byte shifted in on MISO.
//
//   Frame timeline (edges counted from the accept edge, N = frame bits):
//     SETUP  CLK_DIV cycles, CS low, SCLK low
//     SHIFT  N SCLK periods; rise samples MISO, fall presents next MOSI bit
//     HOLD   CLK_DIV cycles after the last fall, CS low, SCLK low
//     close  next edge: CS high, rsp_valid pulse, read data loaded
//     GAP    CS high for CLK_DIV cycles, then back to IDLE / req_ready
//   rsp_valid therefore rises (2 + 2N) * CLK_DIV + 1 edges after accept.
//
// Ports
//   clk, rst_n      system clock, synchronous active-low reset
//   req_valid/ready request handshake; accepted when both high at an edge
//   req_we          1 = write, 0 = read
//   req_addr        byte address (ADDR_W bits)
//   req_wdata       write data byte
//   rsp_valid       one-cycle completion pulse
//   rsp_rdata       read data, updated with rsp_valid on reads only
//   busy            high from accept until the FSM is back in IDLE
//   spi_cs_n        SRAM chip select, active low
//   spi_sclk        SPI clock
//   spi_mosi        serial data out
//   spi_miso        serial data in
// -----------------------------------------------------------------------------
module spi_mem_master
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int NBITS = 16 + ADDR_W;
    localparam int CW    = $clog2(CLK_DIV + 1);
    localparam int BW    = $clog2(NBITS + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    // Only the bits still to be sent after the one already on MOSI are kept.
    logic [NBITS-2:0]  tx_q, tx_d;
    logic [7:0]        rx_q, rx_d;
    logic              we_q, we_d;
    logic              cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rdata_q, rdata_d;

    logic [NBITS-1:0]  frame;
    logic              sclk_en;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              sample_stb;
    logic              shift_stb;

    assign frame = {cmd_for(req_we), req_addr, (req_we ? req_wdata : 8'h00)};

    // -------------------------------------------------------------------------
    // SCLK generation: only runs during SHIFT, so SETUP and HOLD see SCLK low.
    // -------------------------------------------------------------------------
    assign sclk_en = (state_q == SHIFT);

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sclk_en),
        .sclk  (spi_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // Mode 0 samples on the leading edge and shifts on the trailing edge.
    assign sample_stb = (SPI_CPHA == 1'b0) ? sclk_rise : sclk_fall;
    assign shift_stb  = (SPI_CPHA == 1'b0) ? sclk_fall : sclk_rise;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement leaves one unassigned and no latch appears.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        we_d        = we_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;

        unique case (state_q)
            IDLE: begin
                // ready comes up one edge after reset release and stays up
                // until a request is taken.
                ready_d = 1'b1;
                if (req_valid && ready_q) begin
                    state_d   = SETUP;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    tx_d      = frame[NBITS-2:0];
                    we_d      = req_we;
                    cs_n_d    = 1'b0;
                    mosi_d    = frame[NBITS-1];
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                end
            end

            SETUP: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SHIFT: begin
                if (sample_stb) begin
                    // Only the final data byte matters, so 8 bits of history
                    // are enough.
                    rx_d = {rx_q[6:0], spi_miso};
                end
                if (shift_stb) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BW'(NBITS - 1)) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        mosi_d  = 1'b0;
                    end else begin
                        mosi_d = tx_q[NBITS-2];
                        tx_d   = {tx_q[NBITS-3:0], 1'b0};
                    end
                end
            end

            HOLD: begin
                // Counts CLK_DIV full cycles of CS-low/SCLK-low after the last
                // fall; the frame closes on the edge that follows them.
                if (cnt_q == CW'(CLK_DIV)) begin
                    state_d     = GAP;
                    cnt_d       = '0;
                    cs_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            GAP: begin
                // Minimum CS-high time before the next frame can start.
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers. A reset mid-frame lands here directly: CS
    // rises, the FSM drops to IDLE and the partial frame is discarded without
    // a response pulse.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            we_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            we_q        <= we_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign busy      = busy_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = mosi_q;

endmodule : spi_mem_master
